// File: rtl/zl_deinterleaver_pkg.sv
// Shared DVB-S convolutional (de)interleaver constants, sync-state encoding and helpers.
package zl_deinterleaver_pkg;

    localparam int         I            = 12;
    localparam int         M            = 17;
    localparam int         Packet_len   = 204;
    localparam logic [7:0] Sync_byte    = 8'h47;
    localparam int         Ptr_width    = 8;
    localparam int         N_ptrs_width = 4;
    localparam int         Total_delay  = 2244;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_t;

    // Inverted sync (0xB8) marks the start of every 8-packet randomisation group.
    function automatic logic is_sync(input logic [7:0] b);
        return (b == Sync_byte) || (b == ~Sync_byte);
    endfunction

    function automatic logic [Ptr_width-1:0] arm_delay(input int j);
        return Ptr_width'((I - 1 - j) * M);
    endfunction

endpackage

// File: rtl/zl_fifo_sc.sv
// Single-clock FIFO, power-of-two depth.
// Latency: written entry visible on o_rd_vld the cycle after the write.
// Backpressure: o_wr_rdy drops when full; pop on o_rd_vld & i_rd_rdy.
module zl_fifo_sc #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_vld,
    output logic          o_wr_rdy,
    input  logic [DW-1:0] i_wr_dat,
    output logic          o_rd_vld,
    input  logic          i_rd_rdy,
    output logic [DW-1:0] o_rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_wr_rdy = (r_count != (AW+1)'(DEPTH));
    assign o_rd_vld = (r_count != '0);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_wr     = i_wr_vld & o_wr_rdy;
    assign w_rd     = o_rd_vld & i_rd_rdy;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/zl_sdp_ram.sv
// Simple dual-port RAM, one write and one read port, read-old-data on collision.
// Latency: 2 cycles from read address to o_rd_dat.
// Backpressure: none.
module zl_sdp_ram #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_dat,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_dat
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q1;
    logic [DW-1:0] r_q2;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_q1 <= r_mem[i_rd_addr];
        end
        r_q2 <= r_q1;
    end

    assign o_rd_dat = r_q2;

endmodule

// File: rtl/zl_ts_sync_tracker.sv
// HUNT/VERIFY/LOCKED packet-sync tracker with packet byte counter; ZL_DEINTERLEAVER_PRIME_MASK_EN masks stale output.
// Latency: combinational decode of the accepted byte; state updates on that edge.
// Backpressure: acts only on i_acc, never stalls by itself.
module zl_ts_sync_tracker #(
    parameter int Lock_count = 3,
    parameter int Loss_count = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_acc,
    input  logic [7:0] i_dat,
    output logic       o_advance,
    output logic       o_restart,
    output logic       o_push,
    output logic       o_sop,
    output logic       o_locked
);
    import zl_deinterleaver_pkg::*;

    sync_state_t r_state;
    sync_state_t w_state_nxt;
    logic [2:0]  r_hits;
    logic [2:0]  w_hits_nxt;
    logic [2:0]  r_misses;
    logic [2:0]  w_misses_nxt;
    logic [7:0]  r_count;
    logic [7:0]  w_count_nxt;
    logic [7:0]  w_count_inc;
    logic        w_sync;
    logic        w_cnt0;
    logic        w_push_raw;

    assign w_sync      = is_sync(i_dat);
    assign w_cnt0      = (r_count == '0);
    assign w_count_inc = (r_count == 8'(Packet_len - 1)) ? '0 : r_count + 8'd1;
    assign o_sop       = w_cnt0;
    assign o_locked    = (r_state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_HUNT;
            r_hits   <= '0;
            r_misses <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hits   <= w_hits_nxt;
            r_misses <= w_misses_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hits_nxt   = r_hits;
        w_misses_nxt = r_misses;
        w_count_nxt  = r_count;
        o_advance    = 1'b0;
        o_restart    = 1'b0;
        w_push_raw   = 1'b0;
        if (i_acc) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_sync) begin
                        w_state_nxt  = (Lock_count <= 1) ? ST_LOCKED : ST_VERIFY;
                        w_hits_nxt   = 3'd1;
                        w_misses_nxt = '0;
                        w_count_nxt  = 8'd1;
                        o_advance    = 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (w_cnt0 && !w_sync) begin
                        w_state_nxt = ST_HUNT;
                        w_count_nxt = '0;
                        o_restart   = 1'b1;
                    end else begin
                        o_advance   = 1'b1;
                        w_count_nxt = w_count_inc;
                        if (w_cnt0) begin
                            w_hits_nxt = r_hits + 3'd1;
                            if (r_hits + 3'd1 == 3'(Lock_count)) begin
                                w_state_nxt  = ST_LOCKED;
                                w_misses_nxt = '0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    // A miss below the loss threshold keeps the commutator in step.
                    if (w_cnt0 && !w_sync && (r_misses + 3'd1 == 3'(Loss_count))) begin
                        w_state_nxt = ST_HUNT;
                        w_count_nxt = '0;
                        o_restart   = 1'b1;
                    end else begin
                        o_advance   = 1'b1;
                        w_push_raw  = 1'b1;
                        w_count_nxt = w_count_inc;
                        if (w_cnt0) begin
                            w_misses_nxt = w_sync ? 3'd0 : r_misses + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_count_nxt = '0;
                    o_restart   = 1'b1;
                end
            endcase
        end
    end

`ifdef ZL_DEINTERLEAVER_PRIME_MASK_EN
    logic [11:0] r_prime;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prime <= '0;
        end else if ((w_state_nxt == ST_LOCKED) && (r_state != ST_LOCKED)) begin
            r_prime <= 12'(Total_delay);
        end else if (w_push_raw && (r_prime != '0)) begin
            r_prime <= r_prime - 12'd1;
        end
    end

    assign o_push = w_push_raw && (r_prime == '0);
`else
    assign o_push = w_push_raw;
`endif

endmodule

// File: rtl/zl_deinterleaver.sv
// DVB-S convolutional deinterleaver (I=12, M=17); optional ZL_DEINTERLEAVER_PRIME_MASK_EN drops the first 2244 locked bytes.
// Latency: 3 cycles from accepted byte to data_out_req with empty FIFOs; 2244-byte stream delay.
// Backpressure: data_in_ack follows token FIFO space while locked; data FIFO is gated by tokens.
module zl_deinterleaver #(
    parameter int Lock_count = 3,
    parameter int Loss_count = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in_req,
    output logic       data_in_ack,
    input  logic [7:0] data_in,
    output logic       data_out_req,
    input  logic       data_out_ack,
    output logic [7:0] data_out,
    output logic       data_out_sop,
    output logic       locked
);
    import zl_deinterleaver_pkg::*;

    localparam int AW = N_ptrs_width + Ptr_width;

    logic [N_ptrs_width-1:0] r_ptr_select;
    logic [Ptr_width-1:0]    r_rd_ptr [I];
    logic [Ptr_width-1:0]    r_wr_ptr [I];
    logic [1:0]              r_push_d;
    logic [1:0]              r_cf_d;
    logic [7:0]              r_din_d1;
    logic [7:0]              r_din_d2;

    logic          w_acc;
    logic          w_advance;
    logic          w_restart;
    logic          w_push;
    logic          w_sop;
    logic          w_locked;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_ram_q;
    logic [7:0]    w_dat_in;
    logic          w_tok_rdy;
    logic          w_tok_vld;
    logic          w_tok_sop;
    logic          w_dat_rdy;
    logic          w_dat_vld;
    logic [7:0]    w_dat_q;
    logic          w_pop;

    assign data_in_ack  = w_locked ? w_tok_rdy : 1'b1;
    assign w_acc        = data_in_req & data_in_ack;
    assign w_wr_addr    = {r_ptr_select, r_wr_ptr[r_ptr_select]};
    assign w_rd_addr    = {r_ptr_select, r_rd_ptr[r_ptr_select]};
    assign data_out_req = w_tok_vld & w_dat_vld;
    assign w_pop        = data_out_req & data_out_ack;
    assign data_out     = w_dat_q;
    assign data_out_sop = data_out_req & w_tok_sop;
    assign locked       = w_locked;

    zl_ts_sync_tracker #(
        .Lock_count (Lock_count),
        .Loss_count (Loss_count)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_acc     (w_acc),
        .i_dat     (data_in),
        .o_advance (w_advance),
        .o_restart (w_restart),
        .o_push    (w_push),
        .o_sop     (w_sop),
        .o_locked  (w_locked)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr_select <= '0;
            for (int j = 0; j < I; j++) begin
                r_rd_ptr[j] <= '0;
                r_wr_ptr[j] <= arm_delay(j);
            end
        end else if (w_restart) begin
            r_ptr_select <= '0;
        end else if (w_advance) begin
            r_ptr_select <= (r_ptr_select == N_ptrs_width'(I - 1)) ? '0 : r_ptr_select + 1'b1;
            r_rd_ptr[r_ptr_select] <= r_rd_ptr[r_ptr_select] + 1'b1;
            r_wr_ptr[r_ptr_select] <= r_wr_ptr[r_ptr_select] + 1'b1;
        end
    end

    zl_sdp_ram #(
        .AW (AW),
        .DW (8)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_advance),
        .i_wr_addr (w_wr_addr),
        .i_wr_dat  (data_in),
        .i_rd_en   (w_advance),
        .i_rd_addr (w_rd_addr),
        .o_rd_dat  (w_ram_q)
    );

    // Arm 11 reads the address it writes; the RAM returns old data, so bypass with data_in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_push_d <= '0;
            r_cf_d   <= '0;
            r_din_d1 <= '0;
            r_din_d2 <= '0;
        end else begin
            r_push_d <= {r_push_d[0], w_push};
            r_cf_d   <= {r_cf_d[0], w_advance & (w_wr_addr == w_rd_addr)};
            r_din_d1 <= data_in;
            r_din_d2 <= r_din_d1;
        end
    end

    assign w_dat_in = r_cf_d[1] ? r_din_d2 : w_ram_q;

    zl_fifo_sc #(
        .DW    (1),
        .DEPTH (4)
    ) u_tok_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (w_push),
        .o_wr_rdy (w_tok_rdy),
        .i_wr_dat (w_sop),
        .o_rd_vld (w_tok_vld),
        .i_rd_rdy (w_pop),
        .o_rd_dat (w_tok_sop)
    );

    zl_fifo_sc #(
        .DW    (8),
        .DEPTH (4)
    ) u_dat_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (r_push_d[1] & w_dat_rdy),
        .o_wr_rdy (w_dat_rdy),
        .i_wr_dat (w_dat_in),
        .o_rd_vld (w_dat_vld),
        .i_rd_rdy (w_pop),
        .o_rd_dat (w_dat_q)
    );

endmodule

// File: tb/tb_zl_deinterleaver.sv
// Directed bench: interleaved packet stream with false sync, sync misses, lock loss, backpressure and arm-11 latency.
`timescale 1ns/1ps
module tb_zl_deinterleaver;

    localparam int N_PKT     = 23;
    localparam int N_SRC     = N_PKT * 204;
    localparam int N_JUNK    = 220;
    localparam int FIRST_OUT = 409;
    localparam int LOSS_AT   = 22 * 204;
    localparam int N_OUT     = LOSS_AT - FIRST_OUT;
    localparam int LAT_IDX   = 1007;
    localparam int BP_IDX    = 1500;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_in_req = 1'b0;
    logic       data_in_ack;
    logic [7:0] data_in = 8'h00;
    logic       data_out_req;
    logic       data_out_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_out_sop;
    logic       locked;

    logic [7:0] src [N_SRC];
    logic [7:0] il  [N_SRC];

    int n_checks = 0;
    int n_errors = 0;
    int out_m    = FIRST_OUT;
    int n_out    = 0;
    int ack_mode = 0;
    bit mon_en   = 1'b0;
    bit saw_stall = 1'b0;

    zl_deinterleaver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in_req  (data_in_req),
        .data_in_ack  (data_in_ack),
        .data_in      (data_in),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .data_out     (data_out),
        .data_out_sop (data_out_sop),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        data_in     = b;
        data_in_req = 1'b1;
        while (data_in_ack !== 1'b1) begin
            if (waited == 2000) begin
                chk("in_ack_timeout", {31'd0, data_in_ack}, 32'd1);
                break;
            end
            saw_stall = 1'b1;
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        data_in_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && data_out_req && data_out_ack) begin
            chk("out_idx_range", {31'd0, out_m < LOSS_AT}, 32'd1);
            if (out_m < LOSS_AT) begin
                chk("sop", {31'd0, data_out_sop}, {31'd0, (out_m % 204) == 0});
                if (out_m >= 2244) chk("data", {24'd0, data_out}, {24'd0, src[out_m - 2244]});
                if (out_m % 12 == 11) chk("arm11", {24'd0, data_out}, {24'd0, il[out_m]});
            end
            out_m++;
            n_out++;
        end
        case (ack_mode)
            0:       data_out_ack = 1'b0;
            1:       data_out_ack = 1'b1;
            default: data_out_ack = ($urandom_range(0, 99) < 30);
        endcase
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog n_out=%0d exp=%0d", n_out, N_OUT);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N_SRC; k++) begin
            logic [7:0] p;
            int pkt;
            pkt = k / 204;
            p = 8'((k * 37 + (k >> 5)) & 255);
            if (p == 8'h47 || p == 8'hB8) p = p ^ 8'h01;
            if (k % 204 == 0) begin
                p = (pkt % 8 == 7) ? 8'hB8 : 8'h47;
                if (pkt == 14 || pkt == 15 || pkt == 20 || pkt == 21 || pkt == 22) p = 8'h46;
            end
            src[k] = p;
        end
        for (int k = 0; k < N_SRC; k++) begin
            int d;
            d = 204 * (k % 12);
            il[k] = (k >= d) ? src[k - d] : 8'h00;
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_req", {31'd0, data_out_req}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_in_ack", {31'd0, data_in_ack}, 32'd1);
        chk("rst_sop", {31'd0, data_out_sop}, 32'd0);

        // Lock with no output drain until the token FIFO fills.
        for (int k = 0; k <= FIRST_OUT + 3; k++) send_byte(il[k]);
        repeat (3) @(negedge clk);
        chk("bp_locked", {31'd0, locked}, 32'd1);
        chk("bp_tokens", {29'd0, dut.u_tok_fifo.r_count}, 32'd4);
        chk("bp_in_ack", {31'd0, data_in_ack}, 32'd0);
        chk("bp_out_req", {31'd0, data_out_req}, 32'd1);

        data_in     = il[FIRST_OUT + 4];
        data_in_req = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        data_in_req = 1'b0;
        chk("mrst_out_req", {31'd0, data_out_req}, 32'd0);
        chk("mrst_locked", {31'd0, locked}, 32'd0);
        chk("mrst_in_ack", {31'd0, data_in_ack}, 32'd1);
        chk("mrst_tok_cnt", {29'd0, dut.u_tok_fifo.r_count}, 32'd0);
        chk("mrst_dat_cnt", {29'd0, dut.u_dat_fifo.r_count}, 32'd0);

        mon_en   = 1'b1;
        ack_mode = 1;
        for (int n = 0; n < N_JUNK; n++) begin
            send_byte((n == 10) ? 8'h47 : 8'((n * 3) & 63));
            if (n == 10) chk("false_verify_sel", {28'd0, dut.r_ptr_select}, 32'd1);
            if (n == 214) begin
                chk("false_hunt_sel", {28'd0, dut.r_ptr_select}, 32'd0);
                chk("false_hunt_lock", {31'd0, locked}, 32'd0);
            end
        end

        for (int k = 0; k < N_SRC; k++) begin
            if (k == BP_IDX) ack_mode = 2;
            if (k == LAT_IDX) begin
                repeat (8) @(negedge clk);
                chk("lat_idle", {31'd0, data_out_req}, 32'd0);
                send_byte(il[k]);
                chk("lat_c1", {31'd0, data_out_req}, 32'd0);
                @(negedge clk);
                chk("lat_c2", {31'd0, data_out_req}, 32'd0);
                @(negedge clk);
                chk("lat_c3", {31'd0, data_out_req}, 32'd1);
                chk("lat_val", {24'd0, data_out}, {24'd0, il[k]});
            end else begin
                send_byte(il[k]);
            end
            if (k == 407) chk("lock_before_3rd", {31'd0, locked}, 32'd0);
            if (k == 408) chk("lock_on_3rd", {31'd0, locked}, 32'd1);
            if (k == 15 * 204) chk("hold_2_miss", {31'd0, locked}, 32'd1);
            if (k == 16 * 204) chk("hold_resync", {31'd0, locked}, 32'd1);
            if (k == LOSS_AT - 204) chk("hold_before_loss", {31'd0, locked}, 32'd1);
            if (k == LOSS_AT) chk("loss_3rd_miss", {31'd0, locked}, 32'd0);
        end

        for (int t = 0; t < 4000 && n_out < N_OUT; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("out_count", n_out, N_OUT);
        chk("stall_seen", {31'd0, saw_stall}, 32'd1);
        chk("drained_req", {31'd0, data_out_req}, 32'd0);
        chk("drained_tok", {29'd0, dut.u_tok_fifo.r_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
